simpson_integrator_seq: RTL and testbench
=========================================

Name: simpson_integrator_seq

Overview:
Parametrised, handshake-driven successor of the board-level Simpson's-rule integrator FSM. It accepts polynomial coefficients a_0..a_DEGREE and integer limits a, b through a valid/ready load port. It evaluates f(x) = sum a_k*x^k with one shared sequential Horner MAC, and accumulates the composite Simpson sum, with a trapezoid correction when the interval count is odd. It reports the result, or an error flag, through a valid/ready output port that feeds the seven-segment display path or a host.

Parameters:
WIDTH, 16, width of coefficients, limits and x values (unsigned)
DEGREE, 3, polynomial degree (DEGREE+1 coefficients, DEGREE >= 1)
ACC_WIDTH, 32, width of f(x), partial sums and result (unsigned, modulo 2^ACC_WIDTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  load beat valid
in_ready  out  1  block accepts a load beat
in_data  in  WIDTH  load beat payload
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_data  out  ACC_WIDTH  integral result
out_err  out  1  qualified by out_valid; 1 = invalid limits (a >= b)
busy  out  1  high in every state except LOAD

Behaviour:
- Reset (async, rst_n=0): state=LOAD, beat counter=0, in_ready=1, out_valid=0, out_err=0, out_data=0, busy=0, accumulator=0.
- A beat transfers when in_valid && in_ready. Beats arrive in the order a_0, a_1, ..., a_DEGREE, a, b, for DEGREE+3 beats total. in_ready=1 only in LOAD.
- The edge accepting b moves to CHECK. The accumulator clears on entry to CHECK.
- CHECK (1 cycle):
  - a >= b: go to DONE with err=1, result=0.
  - otherwise: n = b-a. If n is odd, go to TRAP; if even, go to SIMP.
- Point evaluation (E = DEGREE+1 cycles):
  - one load cycle: h = a_DEGREE.
  - DEGREE MAC cycles: h = h*x + a_k, for k = DEGREE-1 down to 0.
  - All products and sums are truncated to ACC_WIDTH.
- TRAP:
  - Evaluate f(b-1), then f(b).
  - One accumulate cycle: acc += floor((f(b-1)+f(b))/2) (sum formed in ACC_WIDTH+1 bits), b <= b-1.
  - Then go to SIMP. Total 2E+1 cycles.
- SIMP, with P = floor(n/2) pairs:
  - If P=0, go straight to DONE.
  - First pair: evaluate f(a), f(a+1), f(a+2), then one accumulate cycle: acc += floor((f0 + 4*f1 + f2)/3). The numerator is formed in ACC_WIDTH+3 bits; the quotient is truncated to ACC_WIDTH.
  - Later pairs: f(a+2) of the previous pair is cached as f0. Evaluate only f(a+1) and f(a+2), then accumulate (2E+1 cycles per pair).
  - a <= a+2 on each accumulate cycle. Exit to DONE when a == b after the update.
- DONE:
  - out_valid=1; out_data and out_err hold stable until out_valid && out_ready.
  - On that handshake edge: out_valid=0, state=LOAD, beat counter=0.
  - in_ready=1 from the next cycle.
- Latency L, counted from the edge accepting b to the first cycle out_valid=1:
  - L = 2 + T_trap + T_simp.
  - T_trap = 2E+1 if n is odd, else 0.
  - T_simp = E + P*(2E+1) if P>0, else 0.
  - Error case: L = 2.
- No $finish and no sticky error: an error result is consumed like a normal result, and the block returns to LOAD.
- in_valid while busy is ignored (no beat accepted). out_ready while out_valid=0 has no effect.
- rst_n low at any time (mid-load, mid-eval, in DONE) aborts immediately to reset values. A partially loaded frame is discarded.
- x values are formed in WIDTH bits; since a < b, a+1, a+2 and b-1 never wrap.

Test Plan:
- DEGREE=3. Load 0,0,1,0, a=0, b=2 (f=x^2) -> out_valid exactly 15 cycles after the b beat, out_data=2, out_err=0.
- Load 0,1,0,0, a=0, b=3 (odd n, f=x) -> trapezoid adds 2, Simpson adds 2; out_data=4 at L=24.
- Load 7,0,0,0, a=0, b=4 (constant, two pairs, f(a+2) reuse) -> out_data=28 at L=24, with exactly 5 point evaluations.
- Load any coefficients, a=5, b=5 -> out_valid at L=2, out_err=1, out_data=0; after handshake, in_ready=1 and a new frame computes correctly.
- Backpressure and ignored input: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_data and out_err stay stable and in_ready stays 0. Drive in_valid=1 while busy -> no beat is consumed.
- Assert rst_n=0 mid-SIMP, then run a fresh frame (0,0,1,0, a=0, b=2) -> all outputs return to reset values, and the fresh frame gives out_data=2 at L=15, unaffected by the stale accumulator.

Source files
------------

// File: rtl/simpson_integrator_seq.sv
// Simpson's-rule integrator of f(x) = sum a_k*x^k over the integer limits [a, b].
// Coefficients and limits are loaded through a valid/ready port. Points are
// evaluated with a single shared Horner MAC. An odd interval count is handled
// by one trapezoid on the last interval. The result leaves through a
// valid/ready port.
module simpson_integrator_seq #(
    parameter int WIDTH     = 16,
    parameter int DEGREE    = 3,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_err,
    output logic                 busy
);

    localparam int NBEATS = DEGREE + 3;
    localparam int CW     = $clog2(NBEATS);
    localparam int SW     = $clog2(DEGREE + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CHECK,
        S_EVAL,
        S_ACC_TRAP,
        S_ACC_SIMP,
        S_DONE
    } state_t;

    state_t                 r_state, w_next;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_coef [0:DEGREE];
    logic [WIDTH-1:0]       r_a, r_b;
    logic [ACC_WIDTH-1:0]   r_h, r_f0, r_f1, r_f2, r_acc;
    logic [SW-1:0]          r_step;
    logic [1:0]             r_pt;
    logic                   r_trap, r_err;

    logic                   w_in_fire, w_last_beat, w_eval_last;
    logic [SW-1:0]          w_kidx;
    logic [WIDTH-1:0]       w_x, w_a_plus2, w_b_minus1;
    logic [ACC_WIDTH-1:0]   w_prod, w_h_next, w_trap_add, w_simp_add;
    logic [ACC_WIDTH:0]     w_trap_sum;
    logic [ACC_WIDTH+2:0]   w_simp_num;

    assign w_in_fire   = in_valid && (r_state == S_LOAD);
    assign w_last_beat = w_in_fire && (r_cnt == CW'(NBEATS - 1));
    assign w_eval_last = (r_step == SW'(DEGREE));
    // Step 0 loads a_DEGREE; step s multiplies by x and adds a_(DEGREE-s).
    assign w_kidx      = SW'(DEGREE) - r_step;
    assign w_a_plus2   = r_a + WIDTH'(2);
    assign w_b_minus1  = r_b - WIDTH'(1);

    // Abscissa of the point being evaluated: b-1 or b for the trapezoid, a+pt for Simpson.
    always_comb begin
        w_x = r_a + WIDTH'(r_pt);
        if (r_trap) begin
            w_x = (r_pt == 2'd0) ? w_b_minus1 : r_b;
        end
    end

    assign w_prod     = r_h * ACC_WIDTH'(w_x);
    assign w_h_next   = ((r_step == '0) ? '0 : w_prod) + ACC_WIDTH'(r_coef[w_kidx]);
    assign w_trap_sum = {1'b0, r_f0} + {1'b0, r_f1};
    assign w_trap_add = ACC_WIDTH'(w_trap_sum >> 1);
    assign w_simp_num = {3'b000, r_f0} + {1'b0, r_f1, 2'b00} + {3'b000, r_f2};
    assign w_simp_add = ACC_WIDTH'(w_simp_num / (ACC_WIDTH + 3)'(3));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        w_next    = r_state;
        in_ready  = (r_state == S_LOAD);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_LOAD);
        out_data  = r_acc;
        out_err   = r_err;
        unique case (r_state)
            S_LOAD:     if (w_last_beat) w_next = S_CHECK;
            S_CHECK:    w_next = (r_a >= r_b) ? S_DONE : S_EVAL;
            S_EVAL: begin
                if (w_eval_last) begin
                    if (r_trap) begin
                        if (r_pt == 2'd1) w_next = S_ACC_TRAP;
                    end else if (r_pt == 2'd2) begin
                        w_next = S_ACC_SIMP;
                    end
                end
            end
            S_ACC_TRAP: w_next = (r_a == w_b_minus1) ? S_DONE : S_EVAL;
            S_ACC_SIMP: w_next = (w_a_plus2 == r_b) ? S_DONE : S_EVAL;
            S_DONE:     if (out_ready) w_next = S_LOAD;
            default:    w_next = S_LOAD;
        endcase
    end

    // Coefficient store, written by the first DEGREE+1 beats of a frame.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; every frame overwrites all coefficients before any evaluation reads them.
        if (w_in_fire && (r_cnt <= CW'(DEGREE))) r_coef[r_cnt[SW-1:0]] <= in_data;
    end

    // Datapath: beat counter, limits, Horner MAC, point cache and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_h    <= '0;
            r_f0   <= '0;
            r_f1   <= '0;
            r_f2   <= '0;
            r_acc  <= '0;
            r_step <= '0;
            r_pt   <= '0;
            r_trap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(DEGREE + 1)) r_a <= in_data;
                        if (w_last_beat) begin
                            r_b   <= in_data;
                            r_acc <= '0;
                            r_err <= 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    r_err  <= (r_a >= r_b);
                    r_trap <= r_a[0] ^ r_b[0];
                    r_pt   <= '0;
                    r_step <= '0;
                end
                S_EVAL: begin
                    r_h <= w_h_next;
                    if (w_eval_last) begin
                        r_step <= '0;
                        r_pt   <= r_pt + 2'd1;
                        case (r_pt)
                            2'd0:    r_f0 <= w_h_next;
                            2'd1:    r_f1 <= w_h_next;
                            default: r_f2 <= w_h_next;
                        endcase
                    end else begin
                        r_step <= r_step + SW'(1);
                    end
                end
                S_ACC_TRAP: begin
                    r_acc  <= r_acc + w_trap_add;
                    r_b    <= w_b_minus1;
                    r_trap <= 1'b0;
                    r_pt   <= '0;
                end
                S_ACC_SIMP: begin
                    // f(a+2) of this pair is f(a) of the next one.
                    r_acc <= r_acc + w_simp_add;
                    r_a   <= w_a_plus2;
                    r_f0  <= r_f2;
                    r_pt  <= 2'd1;
                end
                S_DONE: begin
                    if (out_ready) r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simpson_integrator_seq.sv
// Self-checking bench for simpson_integrator_seq: directed frames followed by
// random frames, each compared with a plain-arithmetic reference of the
// integrator's result, error flag and latency.
module tb_simpson_integrator_seq;

    localparam int WIDTH     = 16;
    localparam int DEGREE    = 3;
    localparam int ACC_WIDTH = 32;
    localparam int E         = DEGREE + 1;
    localparam longint MASK  = (longint'(1) << ACC_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_err;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] cf [0:DEGREE];

    simpson_integrator_seq #(.WIDTH(WIDTH), .DEGREE(DEGREE), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // f(x) = sum cf[k] * x^k, modulo 2^ACC_WIDTH.
    function automatic longint f_ref(input longint x);
        longint s = 0;
        longint p = 1;
        for (int k = 0; k <= DEGREE; k++) begin
            s = (s + longint'(cf[k]) * p) & MASK;
            p = (p * x) & MASK;
        end
        return s;
    endfunction

    // Trapezoid on the last interval when the interval count is odd, then composite Simpson.
    task automatic ref_model(input int a, input int b, output longint res, output logic err,
                             output int lat);
        int hi, p;
        longint acc;
        if (a >= b) begin
            res = 0; err = 1'b1; lat = 2;
            return;
        end
        err = 1'b0; acc = 0; hi = b; lat = 2;
        if (((b - a) % 2) == 1) begin
            acc = (f_ref(b - 1) + f_ref(b)) / 2;
            hi  = b - 1;
            lat += 2 * E + 1;
        end
        p = (hi - a) / 2;
        for (int i = 0; i < p; i++) begin
            longint x = longint'(a + 2 * i);
            acc = (acc + ((f_ref(x) + 4 * f_ref(x + 1) + f_ref(x + 2)) / 3)) & MASK;
        end
        if (p > 0) lat += E + p * (2 * E + 1);
        res = acc;
    endtask

    task automatic send_beats(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int i = 0; i < DEGREE + 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            if (i <= DEGREE)          in_data = cf[i];
            else if (i == DEGREE + 1) in_data = a;
            else                      in_data = b;
            if (i == 0) check("in_ready_at_load", 64'(in_ready), 64'd1);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int hold, input bit noise);
        longint res;
        logic   err;
        int     lat, c;
        bit     got;
        ref_model(int'(a), int'(b), res, err, lat);
        send_beats(a, b);
        if (noise) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
        end
        got = 1'b0;
        c   = 1;
        while (c <= 400 && !got) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
            end else begin
                if (c == 1) begin
                    check({tag, "_busy"}, 64'(busy), 64'd1);
                    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
                end
                if (noise) in_data = WIDTH'($urandom);
                c++;
            end
        end
        check({tag, "_latency"}, got ? 64'(c) : 64'hFFFF_FFFF, 64'(lat));
        check({tag, "_data"}, 64'(out_data), 64'(res));
        check({tag, "_err"}, 64'(out_err), 64'(err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_data"}, 64'(out_data), 64'(res));
            check({tag, "_hold_err"}, 64'(out_err), 64'(err));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_post_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_rst_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_rst_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_rst_out_err"}, 64'(out_err), 64'd0);
        check({tag, "_rst_busy"}, 64'(busy), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_cf(input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] c1,
                          input logic [WIDTH-1:0] c2, input logic [WIDTH-1:0] c3);
        cf[0] = c0; cf[1] = c1; cf[2] = c2; cf[3] = c3;
    endtask

    initial begin
        int        n;
        logic [WIDTH-1:0] ra, rb;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_err", 64'(out_err), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // f = x^2 on [0,2]: one Simpson pair.
        set_cf(16'd0, 16'd0, 16'd1, 16'd0);
        run_frame("sq_0_2", 16'd0, 16'd2, 0, 1'b0);

        // f = x on [0,3]: trapezoid then one pair.
        set_cf(16'd0, 16'd1, 16'd0, 16'd0);
        run_frame("lin_0_3", 16'd0, 16'd3, 0, 1'b0);

        // Constant 7 on [0,4] with backpressure and input noise while busy.
        set_cf(16'd7, 16'd0, 16'd0, 16'd0);
        run_frame("const_0_4", 16'd0, 16'd4, 10, 1'b1);

        // Invalid limits, then a normal frame.
        set_cf(16'd3, 16'd9, 16'd1, 16'd4);
        run_frame("err_5_5", 16'd5, 16'd5, 3, 1'b1);
        set_cf(16'd0, 16'd0, 16'd1, 16'd0);
        run_frame("sq_after_err", 16'd0, 16'd2, 0, 1'b0);

        // Reset mid-load discards the partial frame.
        set_cf(16'd9, 16'd9, 16'd9, 16'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = cf[i];
            @(posedge clk);
        end
        pulse_reset("midload");
        set_cf(16'd0, 16'd0, 16'd1, 16'd0);
        run_frame("sq_after_midload", 16'd0, 16'd2, 0, 1'b0);

        // Reset mid-Simpson with a non-zero accumulator, then a fresh frame.
        set_cf(16'd500, 16'd3, 16'd2, 16'd1);
        send_beats(16'd0, 16'd8);
        repeat (20) @(negedge clk);
        pulse_reset("midsimp");
        set_cf(16'd0, 16'd0, 16'd1, 16'd0);
        run_frame("sq_after_midsimp", 16'd0, 16'd2, 0, 1'b0);

        // Random frames, including invalid limits.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k <= DEGREE; k++) cf[k] = WIDTH'($urandom);
            ra = WIDTH'($urandom_range(2, 65000));
            n  = int'($urandom_range(0, 11)) - 2;
            rb = WIDTH'(int'(ra) + n);
            run_frame("rand", ra, rb, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
